// File: rtl/key_debouncer.sv
// Pushbutton conditioner: per-key 2-flop synchroniser plus debounce FSM,
// producing a clean active-low level and 1-cycle press/release strobes.
module key_debouncer #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [N_KEYS-1:0] KEY_raw,
  output logic [N_KEYS-1:0] KEY_clean,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  typedef enum logic [1:0] {REL, PRESS_W, PRSD, REL_W} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle window the first new sample already qualifies.
  localparam bit ONE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;

  // Sync flops idle high so a released key does not look like a press after reset.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= KEY_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clean_q, clean_nxt;
    logic             press_q, press_nxt;
    logic             release_q, release_nxt;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
        state     <= REL;
        cnt       <= '0;
        clean_q   <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        clean_q   <= clean_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // Any opposite sample during a wait state throws the partial count away.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      clean_nxt   = clean_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        REL: begin
          clean_nxt = 1'b1;
          if (!s2[i]) begin
            if (ONE_SAMPLE) begin
              state_nxt = PRSD;
              clean_nxt = 1'b0;
              press_nxt = 1'b1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = PRESS_W;
              cnt_nxt   = CNT_W'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        PRESS_W: begin
          clean_nxt = 1'b1;
          if (s2[i]) begin
            state_nxt = REL;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRSD;
            clean_nxt = 1'b0;
            press_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PRSD: begin
          clean_nxt = 1'b0;
          if (s2[i]) begin
            if (ONE_SAMPLE) begin
              state_nxt   = REL;
              clean_nxt   = 1'b1;
              release_nxt = 1'b1;
              cnt_nxt     = '0;
            end else begin
              state_nxt = REL_W;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        REL_W: begin
          clean_nxt = 1'b0;
          if (!s2[i]) begin
            state_nxt = PRSD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = REL;
            clean_nxt   = 1'b1;
            release_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = REL;
          cnt_nxt   = '0;
          clean_nxt = 1'b1;
        end
      endcase
    end

    assign KEY_clean[i]   = clean_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with an 8-cycle debounce window:
// reset, clean press/release, bounce, short glitch, dual keys, reset mid-count.
module tb_key_debouncer;

  logic       CLOCK_50;
  logic       Resetn;
  logic [1:0] KEY_raw;
  logic [1:0] KEY_clean;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int testsRun    = 0;
  int testsFailed = 0;
  int pressCount   [2];
  int releaseCount [2];

  key_debouncer #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn(Resetn),
    .KEY_raw(KEY_raw),
    .KEY_clean(KEY_clean),
    .key_press(key_press),
    .key_release(key_release)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Tally every strobe so extra or missing pulses between checkpoints show up.
  always @(negedge CLOCK_50) begin
    for (int i = 0; i < 2; i++) begin
      if (key_press[i])   pressCount[i]++;
      if (key_release[i]) releaseCount[i]++;
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] raw, input int n);
    KEY_raw = raw;
    stepCycles(n);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expClean,
                             input logic [1:0] expPress, input logic [1:0] expRelease);
    logic [5:0] observed;
    logic [5:0] expected;
    observed = {KEY_clean, key_press, key_release};
    expected = {expClean, expPress, expRelease};
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("FAIL %s observed clean/press/release=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    Resetn  = 1'b0;
    KEY_raw = 2'b11;

    // 1: reset held while the keys chatter
    for (int i = 0; i < 10; i++) begin
      KEY_raw = 2'($urandom_range(0, 3));
      stepCycles(1);
      checkOutput("reset_hold", 2'b11, 2'b00, 2'b00);
    end
    KEY_raw = 2'b11;
    stepCycles(1);
    Resetn = 1'b1;
    stepCycles(1);
    checkOutput("post_reset_c1", 2'b11, 2'b00, 2'b00);
    stepCycles(2);
    checkOutput("post_reset_c3", 2'b11, 2'b00, 2'b00);

    // 2: clean press of KEY[1], then clean release
    applyStimulus(2'b01, 9);
    checkOutput("press1_t9", 2'b11, 2'b00, 2'b00);
    stepCycles(1);
    checkOutput("press1_t10", 2'b01, 2'b10, 2'b00);
    stepCycles(1);
    checkOutput("press1_t11", 2'b01, 2'b00, 2'b00);
    applyStimulus(2'b11, 9);
    checkOutput("release1_t9", 2'b01, 2'b00, 2'b00);
    stepCycles(1);
    checkOutput("release1_t10", 2'b11, 2'b00, 2'b10);
    stepCycles(1);
    checkOutput("release1_t11", 2'b11, 2'b00, 2'b00);

    // 3: KEY[0] low 5, high 1, low 20
    applyStimulus(2'b10, 5);
    applyStimulus(2'b11, 1);
    checkOutput("bounce_mid", 2'b11, 2'b00, 2'b00);
    applyStimulus(2'b10, 9);
    checkOutput("bounce_t9", 2'b11, 2'b00, 2'b00);
    stepCycles(1);
    checkOutput("bounce_t10", 2'b10, 2'b01, 2'b00);
    stepCycles(10);
    checkOutput("bounce_hold", 2'b10, 2'b00, 2'b00);
    checkCount("bounce_press0_count", pressCount[0], 1);
    applyStimulus(2'b11, 10);
    checkOutput("bounce_release", 2'b11, 2'b00, 2'b01);
    stepCycles(1);

    // 4: a 7-cycle glitch must never reach the clean output
    applyStimulus(2'b10, 7);
    applyStimulus(2'b11, 12);
    checkOutput("glitch7", 2'b11, 2'b00, 2'b00);
    checkCount("glitch_press0_count", pressCount[0], 1);

    // 5: both keys together
    applyStimulus(2'b00, 10);
    checkOutput("both_press", 2'b00, 2'b11, 2'b00);
    stepCycles(1);
    checkOutput("both_held", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b11, 10);
    checkOutput("both_release", 2'b11, 2'b00, 2'b11);
    stepCycles(1);
    checkOutput("both_idle", 2'b11, 2'b00, 2'b00);

    // 6: reset at count 4, then debounce from scratch with keys held
    applyStimulus(2'b00, 6);
    Resetn = 1'b0;
    #1;
    checkOutput("midcount_reset_async", 2'b11, 2'b00, 2'b00);
    stepCycles(2);
    checkOutput("midcount_reset_hold", 2'b11, 2'b00, 2'b00);
    Resetn = 1'b1;
    stepCycles(9);
    checkOutput("after_reset_t9", 2'b11, 2'b00, 2'b00);
    stepCycles(1);
    checkOutput("after_reset_t10", 2'b00, 2'b11, 2'b00);
    stepCycles(1);

    checkCount("press0_total", pressCount[0], 3);
    checkCount("press1_total", pressCount[1], 3);
    checkCount("release0_total", releaseCount[0], 2);
    checkCount("release1_total", releaseCount[1], 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
